audio_frame_sched: RTL and testbench

- Frame scheduler between the audio codec FIFO interface and one shared 16-bit FIR engine.
- Per stereo frame it pops one sample pair from the codec. It then runs left and right through the single FIR in turn, selecting the coefficient/delay bank with flt_chan, and pushes the filtered pair back to the codec.
- Sits in the top level in place of the direct read/write wiring. It owns the codec read/write strobes and the FIR start/done handshake.

---
 rtl/audio_sched_pkg.sv | 11 +
 rtl/sched_chan_seq.sv | 47 ++++
 rtl/audio_frame_sched.sv | 94 +++++++++
 tb/tb_audio_frame_sched.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_sched_pkg.sv
// audio_sched_pkg: shared FSM states, default widths and channel-to-bank mapping
package audio_sched_pkg;
  localparam int DW_DEF = 24;
  localparam int FW_DEF = 16;
  localparam int CH_L = 0;
  localparam int CH_R = 1;
  typedef enum logic [2:0] {IDLE, RD, L_GO, L_WAIT, R_GO, R_WAIT, WR} state_e;
  function automatic logic chan_sel(input int idx);
    return idx != CH_L;
  endfunction
endpackage

// File: rtl/sched_chan_seq.sv
// sched_chan_seq: one channel's FIR start / wait-for-done / timeout sequencer
// ports: go_i/wait_i phase strobes from the top FSM, bypass_i, smp_i raw sample,
//        done_i/flt_out_i FIR result, start_o FIR start, fin_o channel finished,
//        tmo_o timeout pulse, res_o channel result
module sched_chan_seq
  import audio_sched_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int FW  = FW_DEF,
  parameter int TMO = 1023
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          go_i,
  input  logic          wait_i,
  input  logic          bypass_i,
  input  logic [DW-1:0] smp_i,
  input  logic          done_i,
  input  logic [FW-1:0] flt_out_i,
  output logic          start_o,
  output logic          fin_o,
  output logic          tmo_o,
  output logic [DW-1:0] res_o
);
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] res_q, res_d;
  assign start_o = go_i & ~bypass_i;
  // done wins over a timeout landing in the same cycle
  assign tmo_o = wait_i & ~done_i & (cnt_q == TW'(TMO));
  assign fin_o = (go_i & bypass_i) | (wait_i & done_i) | tmo_o;
  assign res_o = res_q;
  always_comb begin
    cnt_d = go_i ? '0 : wait_i ? cnt_q + 1'b1 : cnt_q;
    res_d = ((go_i & bypass_i) | tmo_o) ? smp_i :
            (wait_i & done_i) ? {flt_out_i, {(DW-FW){1'b0}}} : res_q;
  end
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end
endmodule

// File: rtl/audio_frame_sched.sv
// audio_frame_sched: pops a stereo pair, filters L then R through one shared FIR, pushes the pair back
// ports: ck/rst clock and async active-low reset; read_ready/readdata_*/read codec pop side;
//        write_ready/write/writedata_* codec push side; flt_* shared FIR handshake;
//        bypass_l/r per-channel FIR skip; busy frame in flight; err_cnt saturating FIR timeouts
module audio_frame_sched
  import audio_sched_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int FW  = FW_DEF,
  parameter int TMO = 1023,
  parameter int CW  = 8
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          read_ready,
  input  logic [DW-1:0] readdata_left,
  input  logic [DW-1:0] readdata_right,
  output logic          read,
  input  logic          write_ready,
  output logic          write,
  output logic [DW-1:0] writedata_left,
  output logic [DW-1:0] writedata_right,
  output logic [FW-1:0] flt_in,
  output logic          flt_chan,
  output logic          flt_start,
  input  logic [FW-1:0] flt_out,
  input  logic          flt_done,
  input  logic          bypass_l,
  input  logic          bypass_r,
  output logic          busy,
  output logic [CW-1:0] err_cnt
);
  state_e state_q, state_d;
  logic [DW-1:0] smp_l_q, smp_r_q, res_l, res_r, wd_l_q, wd_r_q;
  logic [FW-1:0] flt_in_q;
  logic chan_q;
  logic [CW-1:0] err_q, err_d;
  logic st_l, st_r, fin_l, fin_r, tmo_l, tmo_r;
  sched_chan_seq #(.DW(DW), .FW(FW), .TMO(TMO)) u_left (
    .ck(ck), .rst(rst), .go_i(state_q == L_GO), .wait_i(state_q == L_WAIT),
    .bypass_i(bypass_l), .smp_i(smp_l_q), .done_i(flt_done), .flt_out_i(flt_out),
    .start_o(st_l), .fin_o(fin_l), .tmo_o(tmo_l), .res_o(res_l)
  );
  sched_chan_seq #(.DW(DW), .FW(FW), .TMO(TMO)) u_right (
    .ck(ck), .rst(rst), .go_i(state_q == R_GO), .wait_i(state_q == R_WAIT),
    .bypass_i(bypass_r), .smp_i(smp_r_q), .done_i(flt_done), .flt_out_i(flt_out),
    .start_o(st_r), .fin_o(fin_r), .tmo_o(tmo_r), .res_o(res_r)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         state_d = read_ready ? RD : IDLE;
      RD:           state_d = L_GO;
      L_GO, L_WAIT: state_d = fin_l ? R_GO : L_WAIT;
      R_GO, R_WAIT: state_d = fin_r ? WR : R_WAIT;
      WR:           state_d = write_ready ? IDLE : WR;
      default:      state_d = IDLE;
    endcase
    err_d = ((tmo_l | tmo_r) & ~&err_q) ? err_q + 1'b1 : err_q;
  end
  assign read      = state_q == RD;
  assign write     = (state_q == WR) & write_ready;
  assign busy      = state_q != IDLE;
  assign flt_start = st_l | st_r;
  // FIR-facing and codec-facing outputs are live only while owned, otherwise they hold
  assign flt_chan  = st_l ? chan_sel(CH_L) : st_r ? chan_sel(CH_R) : chan_q;
  assign flt_in    = st_l ? smp_l_q[DW-1 -: FW] : st_r ? smp_r_q[DW-1 -: FW] : flt_in_q;
  assign writedata_left  = (state_q == WR) ? res_l : wd_l_q;
  assign writedata_right = (state_q == WR) ? res_r : wd_r_q;
  assign err_cnt   = err_q;
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      smp_l_q  <= '0;
      smp_r_q  <= '0;
      flt_in_q <= '0;
      chan_q   <= 1'b0;
      wd_l_q   <= '0;
      wd_r_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      if (state_q == IDLE && read_ready) begin
        smp_l_q <= readdata_left;
        smp_r_q <= readdata_right;
      end
      flt_in_q <= flt_in;
      chan_q   <= flt_chan;
      wd_l_q   <= writedata_left;
      wd_r_q   <= writedata_right;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_audio_frame_sched.sv
// tb_audio_frame_sched: directed self-checking bench for audio_frame_sched
module tb_audio_frame_sched;
  localparam int TMO_T = 20;
  logic ck = 0, rst = 0;
  logic read_ready = 0, write_ready = 0, bypass_l = 0, bypass_r = 0;
  logic [23:0] readdata_left = 0, readdata_right = 0;
  logic read, write, flt_chan, flt_start, flt_done, busy;
  logic [23:0] writedata_left, writedata_right;
  logic [15:0] flt_in, flt_out;
  logic [7:0] err_cnt;
  logic stray_done = 0, stray_all = 0, rr_hold = 0, fdone_m = 0;
  logic [15:0] fout = 16'hDEAD;
  int fir_lat = 5, fcnt = 0, cyc = 0, checks = 0, errors = 0;

  audio_frame_sched #(.TMO(TMO_T)) dut (
    .ck(ck), .rst(rst), .read_ready(read_ready), .readdata_left(readdata_left),
    .readdata_right(readdata_right), .read(read), .write_ready(write_ready), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right), .flt_in(flt_in),
    .flt_chan(flt_chan), .flt_start(flt_start), .flt_out(flt_out), .flt_done(flt_done),
    .bypass_l(bypass_l), .bypass_r(bypass_r), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  assign flt_out  = fout;
  assign flt_done = fdone_m | stray_done;

  // FIR model: result in+1, done in the cycle fir_lat after the start cycle; fir_lat=0 never answers
  always @(negedge ck) begin
    fdone_m = 0;
    if (fcnt > 0) begin
      fcnt = fcnt - 1;
      if (fcnt == 0) fdone_m = 1;
    end
    if (flt_start && fir_lat > 0) begin
      fcnt = fir_lat;
      fout = flt_in + 16'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic frame(input logic [23:0] l, input logic [23:0] r, input int wr_hold, input int stray_at,
                       output int rd_at, output int wr_at, output int nrd,
                       output logic [23:0] wl, output logic [23:0] wr, output logic [23:0] wl_mid,
                       output logic [15:0] fi0, output logic [15:0] fi1,
                       output logic fc0, output logic fc1, output logic fcw);
    int k0, n, ns;
    rd_at = -1; wr_at = -1; nrd = 0; ns = 0;
    wl = 0; wr = 0; wl_mid = 0; fi0 = 0; fi1 = 0; fc0 = 0; fc1 = 0; fcw = 0;
    @(negedge ck);
    readdata_left = l; readdata_right = r; read_ready = 1;
    write_ready = (wr_hold == 0);
    stray_done = stray_all | (stray_at == 0);
    k0 = cyc;
    while (wr_at < 0 && cyc - k0 < 400) begin
      @(negedge ck);
      n = cyc - k0;
      write_ready = (n >= wr_hold);
      stray_done = stray_all | (n == stray_at);
      #1;
      if (read) begin
        nrd++;
        if (rd_at < 0) rd_at = n;
        if (!rr_hold) read_ready = 0;
      end
      if (flt_start) begin
        if (ns == 0) begin fi0 = flt_in; fc0 = flt_chan; end
        else begin fi1 = flt_in; fc1 = flt_chan; end
        ns++;
      end
      if (n == 10) wl_mid = writedata_left;
      if (write) begin
        wr_at = n; wl = writedata_left; wr = writedata_right; fcw = flt_chan;
      end
    end
    if (wr_at < 0) check("frame_no_write", 0, 1);
    stray_done = stray_all;
  endtask

  int rd_at, wr_at, nrd, nr, nw, over, bad;
  logic [23:0] wl, wr, wl_mid, last_wl;
  logic [15:0] fi0, fi1;
  logic fc0, fc1, fcw;

  initial begin
    repeat (3) @(negedge ck);
    #1;
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_busy", busy, 0);
    check("rst_start", flt_start, 0);
    check("rst_chan", flt_chan, 0);
    check("rst_flt_in", flt_in, 0);
    check("rst_wd", {writedata_left, writedata_right}, 0);
    check("rst_err", err_cnt, 0);
    @(negedge ck); rst = 1;

    bypass_l = 1; bypass_r = 1;
    frame(24'h123456, 24'hABCDEF, 0, -1, rd_at, wr_at, nrd, wl, wr, wl_mid, fi0, fi1, fc0, fc1, fcw);
    check("byp_read_at", rd_at, 1);
    check("byp_write_at", wr_at, 4);
    check("byp_nread", nrd, 1);
    check("byp_wl", wl, 24'h123456);
    check("byp_wr", wr, 24'hABCDEF);
    @(negedge ck); #1;
    check("byp_idle", busy, 0);
    check("byp_hold_wl", writedata_left, 24'h123456);

    bypass_l = 0; bypass_r = 0; fir_lat = 5;
    frame(24'h100000, 24'h200000, 0, -1, rd_at, wr_at, nrd, wl, wr, wl_mid, fi0, fi1, fc0, fc1, fcw);
    check("flt_fi_l", fi0, 16'h1000);
    check("flt_ch_l", fc0, 0);
    check("flt_fi_r", fi1, 16'h2000);
    check("flt_ch_r", fc1, 1);
    check("flt_write_at", wr_at, 14);
    check("flt_wl", wl, 24'h100100);
    check("flt_wr", wr, 24'h200100);
    check("flt_chan_hold", fcw, 1);
    check("flt_err", err_cnt, 0);

    frame(24'h345678, 24'h456789, 0, 2, rd_at, wr_at, nrd, wl, wr, wl_mid, fi0, fi1, fc0, fc1, fcw);
    check("stray_write_at", wr_at, 14);
    check("stray_wl", wl, 24'h345700);
    check("stray_wr", wr, 24'h456800);

    fir_lat = 0;
    frame(24'h111111, 24'h222222, 0, -1, rd_at, wr_at, nrd, wl, wr, wl_mid, fi0, fi1, fc0, fc1, fcw);
    check("tmo_write_at", wr_at, 2 * TMO_T + 6);
    check("tmo_wl", wl, 24'h111111);
    check("tmo_wr", wr, 24'h222222);
    check("tmo_err1", err_cnt, 2);
    for (int i = 2; i <= 127; i++)
      frame(24'h111111, 24'h222222, 0, -1, rd_at, wr_at, nrd, wl, wr, wl_mid, fi0, fi1, fc0, fc1, fcw);
    check("tmo_err127", err_cnt, 8'hFE);
    frame(24'h111111, 24'h222222, 0, -1, rd_at, wr_at, nrd, wl, wr, wl_mid, fi0, fi1, fc0, fc1, fcw);
    check("tmo_err128", err_cnt, 8'hFF);
    frame(24'h111111, 24'h222222, 0, -1, rd_at, wr_at, nrd, wl, wr, wl_mid, fi0, fi1, fc0, fc1, fcw);
    check("tmo_err_sat", err_cnt, 8'hFF);

    bypass_l = 1; bypass_r = 1; rr_hold = 1;
    frame(24'h0A0B0C, 24'h0D0E0F, 54, -1, rd_at, wr_at, nrd, wl, wr, wl_mid, fi0, fi1, fc0, fc1, fcw);
    check("stall_write_at", wr_at, 54);
    check("stall_nread", nrd, 1);
    check("stall_wd_mid", wl_mid, 24'h0A0B0C);
    check("stall_wr", wr, 24'h0D0E0F);
    @(negedge ck); #1;
    check("stall_after_busy", busy, 0);
    check("stall_after_write", write, 0);
    check("stall_after_hold", writedata_left, 24'h0A0B0C);
    read_ready = 0; rr_hold = 0;

    repeat (3) @(negedge ck);
    bypass_l = 0; bypass_r = 0; fir_lat = 5;
    readdata_left = 24'h0F0F0F; readdata_right = 24'hF0F0F0; read_ready = 1; write_ready = 1;
    begin
      int k0;
      k0 = cyc;
      while (cyc - k0 < 10) begin
        @(negedge ck); #1;
        if (read) read_ready = 0;
      end
    end
    check("mid_chan_r", flt_chan, 1);
    check("mid_busy", busy, 1);
    #1 rst = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rw", {read, write, flt_start}, 0);
    check("arst_chan", flt_chan, 0);
    check("arst_flt_in", flt_in, 0);
    check("arst_wd", {writedata_left, writedata_right}, 0);
    check("arst_err", err_cnt, 0);
    repeat (2) @(negedge ck);
    rst = 1;
    bad = 0;
    repeat (12) begin
      @(negedge ck); #1;
      if (write || read) bad++;
    end
    check("arst_no_write", bad, 0);
    frame(24'h0F0F0F, 24'hF0F0F0, 0, -1, rd_at, wr_at, nrd, wl, wr, wl_mid, fi0, fi1, fc0, fc1, fcw);
    check("post_rst_write_at", wr_at, 14);
    check("post_rst_wl", wl, 24'h0F1000);
    check("post_rst_wr", wr, 24'hF0F100);

    @(negedge ck);
    bypass_l = 1; bypass_r = 1; stray_all = 1; stray_done = 1;
    readdata_left = 24'h5A5A5A; readdata_right = 24'hA5A5A5; read_ready = 1; write_ready = 1;
    nr = 0; nw = 0; over = 0; last_wl = 0;
    for (int n = 0; n < 300 && nw < 10; n++) begin
      @(negedge ck); #1;
      if (read) nr++;
      if (write) begin nw++; last_wl = writedata_left; end
      if (nr - nw > 1 || nr < nw) over++;
    end
    check("cont_writes", nw, 10);
    check("cont_reads", nr, 10);
    check("cont_ratio", over, 0);
    check("cont_wl", last_wl, 24'h5A5A5A);
    read_ready = 0; stray_all = 0; stray_done = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
